alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered result stage directly downstream of the 32-bit ALU. Captures the ALU's `Result`, `Result_Hi` and `Branch_Taken` outputs, and maintains the architectural LO/HI registers written by multiply operations. Selects the write-back value (ALU result, LO or HI, for mflo/mfhi), then presents it to the write-back/PC logic through a one-entry valid/ready register slice.

## Interface
- `WIDTH`, 32, datapath width of results and LO/HI.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ALU outputs below are valid this cycle.
- `in_ready`  out  1  stage can accept this cycle.
- `Result`  in  WIDTH  ALU low/primary result.
- `Result_Hi`  in  WIDTH  ALU high result (upper product word).
- `Branch_Taken`  in  1  ALU branch-condition output.
- `OP_SELECT`  in  5  ALU operation code of the beat; codes 00010 (signed mult) and 00011 (unsigned mult) write LO/HI.
- `ALU_LO_HI`  in  2  write-back select: 00 Result, 01 LO, 10 HI, 11 Result (reserved).
- `out_valid`  out  1  `out_data`/`out_branch` hold a valid beat.
- `out_ready`  in  1  consumer accepts the beat this cycle.
- `out_data`  out  WIDTH  registered write-back value.
- `out_branch`  out  1  registered Branch_Taken of the beat.
- `LO`  out  WIDTH  architectural LO register.
- `HI`  out  WIDTH  architectural HI register.

## Operation
- Accept is `in_valid && in_ready`. Transfer is `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational, so full throughput is one beat per cycle when `out_ready` is held high.
- On accept:
  - `out_data` captures the value selected by `ALU_LO_HI`.
  - `out_branch` captures `Branch_Taken`.
  - `out_valid` is set.
- On accept with `OP_SELECT` equal to 00010 or 00011: `LO <= Result` and `HI <= Result_Hi` on the same edge.
- All other opcodes leave LO/HI unchanged, including SRA, which drives a nonzero `Result_Hi`.
- A LO/HI select reads the LO/HI register values present before the edge:
  - A mult and mflo in the same beat (not legal ISA usage) return the old LO.
  - An mflo/mfhi accepted in any later beat returns the new value.
- If there is a transfer and no accept, `out_valid` clears. `out_data`/`out_branch` keep their last value and are don't-care.
- If there is a transfer and an accept in the same cycle, the new beat replaces the old one and `out_valid` stays 1.
- If neither occurs, all state holds.
- With `in_valid = 0`, ALU inputs are ignored, and LO/HI never change regardless of `OP_SELECT`.
- While `out_valid && !out_ready`:
  - `out_data` and `out_branch` are held stable.
  - `in_ready = 0`.
  - No LO/HI write can occur.

## Timing
- Reset (synchronous, `rst` high at a rising edge) drives:
  - `out_valid = 0`
  - `out_data = 0`
  - `out_branch = 0`
  - `LO = 0`
  - `HI = 0`
- Reset overrides any simultaneous accept.
- Reset mid-hold discards the pending beat.
- `in_ready` is 1 in the cycle after reset.
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid = 1` after edge N; it is consumable at edge N+1.
- LO/HI update at the accept edge. They are visible on the `LO`/`HI` ports after that edge and to the select of the next accepted beat.
- `out_data`, `out_branch`, `LO`, `HI` and `out_valid` are direct register outputs, with no combinational path from inputs. `in_ready` is the only combinational output, and it depends on `out_ready` and `out_valid` only.
- No arithmetic is performed: values are stored at full `WIDTH` with no truncation or extension.

## Test plan
- Reset, then unsigned mult (`OP_SELECT = 00011`, `Result = 0x00000000`, `Result_Hi = 0x00000002`, `ALU_LO_HI = 00`) accepted -> next cycle `LO = 0`, `HI = 2`, `out_data = 0`, `out_valid = 1`. Following beat with `ALU_LO_HI = 10` -> `out_data = 0x00000002`.
- SRA beat (`OP_SELECT = 01001`, `Result = 0xF8000004`, `Result_Hi = 0xFFFFFFFF`) -> `out_data = 0xF8000004`; `LO`/`HI` unchanged from the prior values (0 and 2).
- Backpressure: `out_ready = 0` for 3 cycles with `in_valid = 1` -> `in_ready = 0`; `out_data` held at the first beat; no LO/HI writes, even with a mult opcode presented. Releasing `out_ready` transfers one beat and accepts the next in the same cycle.
- Streaming: `out_ready = 1`, four back-to-back beats with ADD results 25, 15, -40 (0xFFFFFFD8), 0x1234 -> `out_data` shows them in consecutive cycles, `out_valid` continuously 1.
- Branch: beat with `Branch_Taken = 1` (BGTZ, `OP_SELECT = 01111`) then `Branch_Taken = 0` (BLEZ) -> `out_branch` = 1 then 0 in successive cycles.
- Signed mult result `LO = 0xFFFFFFD8`, `HI = 0xFFFFFFFF` stored; then `rst` asserted while `out_valid = 1` and `out_ready = 0` -> after the edge, all outputs 0 and `in_ready = 1`.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered result stage after the ALU: holds the architectural LO/HI registers and
// presents the selected write-back value through a one-entry valid/ready slice.
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Result,
    input  logic [WIDTH-1:0] Result_Hi,
    input  logic             Branch_Taken,
    input  logic [4:0]       OP_SELECT,
    input  logic [1:0]       ALU_LO_HI,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_branch,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] HI
);

    localparam logic [4:0] OP_MULT  = 5'b00010;
    localparam logic [4:0] OP_MULTU = 5'b00011;
    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_HI   = 2'b10;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             branch_q, branch_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             accept, transfer, is_mult;

    // LO/HI selects see the register values from before this edge, so a
    // mult and mflo in the same beat return the old LO.
    function automatic logic [WIDTH-1:0] select_wb(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] res,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        case (sel)
            SEL_LO:  select_wb = lo;
            SEL_HI:  select_wb = hi;
            default: select_wb = res;
        endcase
    endfunction

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = valid_q && out_ready;
    assign is_mult  = (OP_SELECT == OP_MULT) || (OP_SELECT == OP_MULTU);

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        branch_d = branch_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        if (accept) begin
            valid_d  = 1'b1;
            data_d   = select_wb(ALU_LO_HI, Result, lo_q, hi_q);
            branch_d = Branch_Taken;
            if (is_mult) begin
                lo_d = Result;
                hi_d = Result_Hi;
            end
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            branch_q <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            branch_q <= branch_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_branch = branch_q;
    assign LO         = lo_q;
    assign HI         = hi_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: scoreboard of expected write-back beats plus a
// reference model of LO/HI and the output valid flag, checked every cycle.
module tb_alu_result_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result_Hi;
    logic             Branch_Taken;
    logic [4:0]       OP_SELECT;
    logic [1:0]       ALU_LO_HI;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_branch;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] HI;

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Result(Result), .Result_Hi(Result_Hi), .Branch_Taken(Branch_Taken),
        .OP_SELECT(OP_SELECT), .ALU_LO_HI(ALU_LO_HI),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_branch(out_branch),
        .LO(LO), .HI(HI)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state, advanced at each falling edge from the inputs that
    // the next rising edge will sample.
    typedef struct packed { logic [WIDTH-1:0] data; logic branch; } beat_t;
    beat_t            sb[$];
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_lo = '0;
    logic [WIDTH-1:0] m_hi = '0;

    always @(negedge clk) begin
        logic  acc, xfer;
        beat_t b;
        if (rst) begin
            m_valid = 1'b0;
            m_lo    = '0;
            m_hi    = '0;
            sb.delete();
        end else begin
            check("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || out_ready)});
            check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("LO", LO, m_lo);
            check("HI", HI, m_hi);
            acc  = in_valid && (!m_valid || out_ready);
            xfer = m_valid && out_ready;
            if (xfer) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    b = sb.pop_front();
                    check("out_data", out_data, b.data);
                    check("out_branch", {31'b0, out_branch}, {31'b0, b.branch});
                end
            end
            if (acc) begin
                case (ALU_LO_HI)
                    2'b01:   b.data = m_lo;
                    2'b10:   b.data = m_hi;
                    default: b.data = Result;
                endcase
                b.branch = Branch_Taken;
                sb.push_back(b);
                if (OP_SELECT == 5'b00010 || OP_SELECT == 5'b00011) begin
                    m_lo = Result;
                    m_hi = Result_Hi;
                end
                m_valid = 1'b1;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic beat(input logic [4:0] op, input logic [WIDTH-1:0] res,
                        input logic [WIDTH-1:0] hi, input logic br, input logic [1:0] sel);
        in_valid     = 1'b1;
        OP_SELECT    = op;
        Result       = res;
        Result_Hi    = hi;
        Branch_Taken = br;
        ALU_LO_HI    = sel;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Result = '0; Result_Hi = '0; Branch_Taken = 1'b0;
        OP_SELECT = '0; ALU_LO_HI = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_LO", LO, 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Unsigned mult, then mfhi
        beat(5'b00011, 32'h0000_0000, 32'h0000_0002, 1'b0, 2'b00);
        check("multu_LO", LO, 32'd0);
        check("multu_HI", HI, 32'd2);
        check("multu_data", out_data, 32'd0);
        check("multu_valid", {31'b0, out_valid}, 32'd1);
        beat(5'b00000, 32'h0000_0007, 32'h0, 1'b0, 2'b10);
        check("mfhi_data", out_data, 32'h0000_0002);

        // SRA drives Result_Hi but must not touch LO/HI
        beat(5'b01001, 32'hF800_0004, 32'hFFFF_FFFF, 1'b0, 2'b00);
        check("sra_data", out_data, 32'hF800_0004);
        check("sra_LO", LO, 32'd0);
        check("sra_HI", HI, 32'd2);
        idle();

        // Backpressure with a mult waiting at the input
        out_ready = 1'b0;
        beat(5'b00000, 32'h0000_AAAA, 32'h0, 1'b0, 2'b00);
        in_valid = 1'b1; OP_SELECT = 5'b00010; Result = 32'h11; Result_Hi = 32'h22; ALU_LO_HI = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_hold_data", out_data, 32'h0000_AAAA);
            check("bp_LO", LO, 32'd0);
            check("bp_HI", HI, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_data", out_data, 32'h11);
        check("bp_release_LO", LO, 32'h11);
        check("bp_release_HI", HI, 32'h22);
        check("bp_release_valid", {31'b0, out_valid}, 32'd1);
        idle();

        // Streaming ADD results
        beat(5'b00000, 32'd25, 32'h0, 1'b0, 2'b00);
        check("stream0", out_data, 32'd25);
        beat(5'b00000, 32'd15, 32'h0, 1'b0, 2'b00);
        check("stream1", out_data, 32'd15);
        beat(5'b00000, 32'hFFFF_FFD8, 32'h0, 1'b0, 2'b00);
        check("stream2", out_data, 32'hFFFF_FFD8);
        beat(5'b00000, 32'h0000_1234, 32'h0, 1'b0, 2'b11);
        check("stream3_rsvd_sel", out_data, 32'h0000_1234);
        check("stream_valid", {31'b0, out_valid}, 32'd1);

        // Branch outcomes
        beat(5'b01111, 32'h0, 32'h0, 1'b1, 2'b00);
        check("bgtz_branch", {31'b0, out_branch}, 32'd1);
        beat(5'b01110, 32'h0, 32'h0, 1'b0, 2'b00);
        check("blez_branch", {31'b0, out_branch}, 32'd0);

        // Mult and mflo in one beat return the old LO; the next mflo sees the new one
        beat(5'b00010, 32'h5, 32'h6, 1'b0, 2'b01);
        check("same_beat_mflo", out_data, 32'h11);
        beat(5'b00000, 32'h0, 32'h0, 1'b0, 2'b01);
        check("next_mflo", out_data, 32'h5);

        // Signed mult, then reset during a stall with a mult presented
        beat(5'b00010, 32'hFFFF_FFD8, 32'hFFFF_FFFF, 1'b0, 2'b00);
        check("mult_LO", LO, 32'hFFFF_FFD8);
        check("mult_HI", HI, 32'hFFFF_FFFF);
        out_ready = 1'b0;
        in_valid = 1'b1; OP_SELECT = 5'b00011; Result = 32'h77; Result_Hi = 32'h88;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst2_out_data", out_data, 32'd0);
        check("rst2_out_branch", {31'b0, out_branch}, 32'd0);
        check("rst2_LO", LO, 32'd0);
        check("rst2_HI", HI, 32'd0);
        check("rst2_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (2) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
